// File: rtl/register_arb_pkg.sv
// Shared definitions for the register write arbiter: FSM encoding and its width.
package register_arb_pkg;

    localparam int STATE_W = 2;

    // Encoding 2'd3 is unused; the FSM treats it as illegal and returns to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/register.sv
// Generic WIDTH-bit register with synchronous reset and load enable.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);

    logic [WIDTH-1:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= '0;
        end else if (load) begin
            r_value <= data_in;
        end
    end

    assign data_out = r_value;

endmodule

// File: rtl/register_write_arbiter_rr_pick.sv
// Rotating-priority search: first set bit of req starting at ptr, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            valid,
    output logic [IDW-1:0]  idx
);

    int w_pos;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        w_pos = 0;
        // Walk from the farthest offset down so the nearest hit to ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_pos = int'(ptr) + k;
            if (w_pos >= NREQ) begin
                w_pos = w_pos - NREQ;
            end
            if (req[w_pos[IDW-1:0]]) begin
                valid = 1'b1;
                idx   = w_pos[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/register_write_arbiter.sv
// Round-robin arbiter sharing one register's load/data_in among NREQ requesters.
// Each transfer takes IDLE -> LOAD -> ACK; every output is decoded from registered state.
module register_write_arbiter #(
    parameter  int WIDTH = 8,
    parameter  int NREQ  = 4,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]         ack,
    output logic                    reg_load,
    output logic [WIDTH-1:0]        reg_data,
    output logic [IDW-1:0]          gnt_id,
    output logic                    busy
);

    import register_arb_pkg::*;

    logic [STATE_W-1:0] r_state;
    logic [IDW-1:0]     r_ptr;
    logic [IDW-1:0]     r_gnt_id;
    logic [WIDTH-1:0]   r_data;

    logic               w_valid;
    logic [IDW-1:0]     w_idx;
    logic [IDW-1:0]     w_ptr_next;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (r_ptr),
        .valid (w_valid),
        .idx   (w_idx)
    );

    assign w_ptr_next = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_ptr    <= '0;
            r_gnt_id <= '0;
            r_data   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_gnt_id <= w_idx;
                        r_data   <= req_data[w_idx*WIDTH +: WIDTH];
                        r_state  <= LOAD;
                    end
                end
                LOAD: begin
                    r_state <= ACK;
                end
                ACK: begin
                    r_ptr   <= w_ptr_next;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        ack = '0;
        if (r_state == ACK) begin
            ack[r_gnt_id] = 1'b1;
        end
    end

    // reg_data holds the last captured word; only reg_load qualifies it.
    assign reg_load = (r_state == LOAD);
    assign busy     = (r_state == LOAD) || (r_state == ACK);
    assign reg_data = r_data;
    assign gnt_id   = r_gnt_id;

endmodule

// File: tb/tb_register_write_arbiter.sv
// Scoreboard bench: arbiter driving a shared register; outputs sampled at negedge.
module tb_register_write_arbiter;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef struct {
        int         id;
        logic [7:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       ack;
    logic                  reg_load;
    logic [WIDTH-1:0]      reg_data;
    logic [IDW-1:0]        gnt_id;
    logic                  busy;
    logic [WIDTH-1:0]      data_out;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   w;

    always #5 clk = ~clk;

    register_write_arbiter #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .reg_load (reg_load),
        .reg_data (reg_data),
        .gnt_id   (gnt_id),
        .busy     (busy)
    );

    register #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (reg_load),
        .data_in  (reg_data),
        .data_out (data_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic post(input int id, input logic [7:0] d);
        req_data[id*WIDTH +: WIDTH] = d;
        req[id] = 1'b1;
        sb.push_back('{id, d});
    endtask

    // Waits up to budget negedges for an ack pulse and compares it with the
    // oldest scoreboard entry; optionally drops that requester's req.
    task automatic expect_ack(input bit drop, input int budget, output int waited);
        bit   got;
        exp_t e;
        got    = 1'b0;
        waited = 0;
        while (!got && waited < budget) begin
            @(negedge clk);
            waited++;
            if (ack != '0) got = 1'b1;
        end
        if (sb.size() == 0) begin
            check("sb_underflow", 32'(ack), 32'd0);
        end else begin
            e = sb.pop_front();
            check("ack",      32'(ack),      32'd1 << e.id);
            check("gnt_id",   32'(gnt_id),   32'(e.id));
            check("data_out", 32'(data_out), 32'(e.data));
            if (got && drop) req[e.id] = 1'b0;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        req      = '0;
        req_data = '0;
        repeat (2) @(negedge clk);
        check("rst_ack",  32'(ack),      32'd0);
        check("rst_busy", 32'(busy),     32'd0);
        check("rst_data", 32'(reg_data), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("idle_ack",  32'(ack),      32'd0);
            check("idle_load", 32'(reg_load), 32'd0);
            check("idle_busy", 32'(busy),     32'd0);
            check("idle_gnt",  32'(gnt_id),   32'd0);
        end
        check("idle_dout", 32'(data_out), 32'd0);

        // All four requesting continuously: strict rotation from ptr=0.
        post(0, 8'h11);
        post(1, 8'h22);
        post(2, 8'h33);
        post(3, 8'h44);
        sb.push_back('{0, 8'h11});
        expect_ack(1'b0, 8, w);
        check("cont_first_lat", 32'(w), 32'd2);
        for (int i = 1; i < 5; i++) begin
            expect_ack(i == 4, 8, w);
            check("cont_gap", 32'(w), 32'd3);
        end
        req = '0;

        // Single request, ptr is now 1.
        @(negedge clk);
        check("post_cont_busy", 32'(busy), 32'd0);
        post(2, 8'h55);
        @(negedge clk);
        check("single_load",  32'(reg_load), 32'd1);
        check("single_busy",  32'(busy),     32'd1);
        check("single_ack0",  32'(ack),      32'd0);
        check("single_rdata", 32'(reg_data), 32'h55);
        expect_ack(1'b1, 4, w);
        check("single_lat",      32'(w),        32'd1);
        check("single_ack_load", 32'(reg_load), 32'd0);
        check("single_ack_busy", 32'(busy),     32'd1);
        @(negedge clk);
        check("single_idle_busy", 32'(busy),     32'd0);
        check("single_retain",    32'(reg_data), 32'h55);

        // ptr=3: requester 3 beats 0; then ptr wraps to 0 and 0 beats 2.
        post(3, 8'h77);
        post(0, 8'hAA);
        expect_ack(1'b1, 6, w);
        post(2, 8'hFF);
        expect_ack(1'b1, 6, w);
        expect_ack(1'b1, 6, w);

        // Requester 1 withdraws and scribbles its data during LOAD.
        @(negedge clk);
        post(1, 8'hC3);
        @(negedge clk);
        check("wd_load", 32'(reg_load), 32'd1);
        req[1] = 1'b0;
        req_data[15:8] = 8'h00;
        expect_ack(1'b0, 4, w);
        check("wd_lat", 32'(w), 32'd1);

        // Reset during LOAD aborts the transfer; req[3] stays high.
        @(negedge clk);
        req_data[31:24] = 8'h9E;
        req[3] = 1'b1;
        @(negedge clk);
        check("mid_load", 32'(reg_load), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ack",  32'(ack),      32'd0);
        check("mid_load_after", 32'(reg_load), 32'd0);
        check("mid_busy", 32'(busy),     32'd0);
        check("mid_gnt",  32'(gnt_id),   32'd0);
        check("mid_data", 32'(reg_data), 32'd0);
        rst = 1'b0;
        sb.push_back('{3, 8'h9E});
        expect_ack(1'b1, 6, w);
        check("mid_restart_lat", 32'(w), 32'd2);

        // Pointer reset: grant 1 moves ptr to 2, reset in IDLE must return it to 0.
        @(negedge clk);
        post(1, 8'h5A);
        expect_ack(1'b1, 6, w);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        post(1, 8'hC5);
        post(3, 8'h3C);
        expect_ack(1'b1, 6, w);
        expect_ack(1'b1, 6, w);
        @(negedge clk);
        check("end_busy", 32'(busy), 32'd0);
        check("end_sb",   32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
